// File: rtl/sysid_read_arbiter_if.sv
// sysid_read_arbiter_if: two requester read ports plus the shared system-ID slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface sysid_read_arbiter_if;
   logic        m0_read;
   logic        m0_address;
   logic        m0_waitrequest;
   logic [31:0] m0_readdata;
   logic        m0_readdatavalid;
   logic        m1_read;
   logic        m1_address;
   logic        m1_waitrequest;
   logic [31:0] m1_readdata;
   logic        m1_readdatavalid;
   logic        s_address;
   logic [31:0] s_readdata;
   modport slave (
      input  m0_read, m0_address, m1_read, m1_address, s_readdata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_waitrequest, m1_readdata, m1_readdatavalid, s_address
   );
   modport master (
      output m0_read, m0_address, m1_read, m1_address, s_readdata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid, s_address
   );
endinterface

// File: rtl/sysid_read_arbiter.sv
// sysid_read_arbiter: round-robin arbiter giving two requesters read access to one system-ID slave.
// One transaction at a time: IDLE grants, ACCESS waits/captures, RESP returns data.
module sysid_read_arbiter #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic                 clock,
   input  logic                 reset_n,
   sysid_read_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   state_t      state, state_nx;
   logic        grant, last_grant, addr, winner, any_read, done;
   logic [3:0]  cnt;
   logic [31:0] rdata0, rdata1;
   assign any_read = bus.m0_read | bus.m1_read;
   // On a tie the requester not served last wins; otherwise the sole requester wins.
   assign winner = (bus.m0_read & bus.m1_read) ? ~last_grant : bus.m1_read;
   assign done = (state == ACCESS) && (cnt == 4'd0);
   always_comb begin
      state_nx             = IDLE;
      bus.m0_waitrequest   = 1'b1;
      bus.m1_waitrequest   = 1'b1;
      bus.m0_readdatavalid = 1'b0;
      bus.m1_readdatavalid = 1'b0;
      bus.s_address        = 1'b0;
      state_nx             = state == IDLE   ? (any_read ? ACCESS : IDLE) :
                             state == ACCESS ? (done ? RESP : ACCESS) : IDLE;
      bus.m0_waitrequest   = !(done && !grant);
      bus.m1_waitrequest   = !(done && grant);
      bus.m0_readdatavalid = (state == RESP) && !grant;
      bus.m1_readdatavalid = (state == RESP) && grant;
      bus.s_address        = (state != IDLE) ? addr : 1'b0;
   end
   assign bus.m0_readdata = rdata0;
   assign bus.m1_readdata = rdata1;
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant      <= 1'b0;
         last_grant <= 1'b1;
         addr       <= 1'b0;
         cnt        <= 4'd0;
         rdata0     <= 32'd0;
         rdata1     <= 32'd0;
      end else begin
         state <= state_nx;
         if (state == IDLE && any_read) begin
            grant <= winner;
            addr  <= winner ? bus.m1_address : bus.m0_address;
            cnt   <= WAIT_INIT;
         end
         if (state == ACCESS && !done) cnt <= cnt - 4'd1;
         if (done) begin
            last_grant <= grant;
            if (grant) rdata1 <= bus.s_readdata;
            else       rdata0 <= bus.s_readdata;
         end
      end
   end
endmodule

// File: tb/tb_sysid_read_arbiter.sv
// tb_sysid_read_arbiter: directed checks of latency, round-robin order, wait states and reset abort.
// Two instances: WAIT_CYCLES=0 (b0) and WAIT_CYCLES=3 (b3), each with its own slave stub.
module tb_sysid_read_arbiter;
   localparam logic [31:0] TS = 32'h51992A75;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;
   sysid_read_arbiter_if b0 ();
   sysid_read_arbiter_if b3 ();
   assign b0.s_readdata = b0.s_address ? TS : 32'd0;
   assign b3.s_readdata = b3.s_address ? TS : 32'd0;
   sysid_read_arbiter #(.WAIT_CYCLES(0)) dut0 (.clock(clk), .reset_n(rst_n), .bus(b0));
   sysid_read_arbiter #(.WAIT_CYCLES(3)) dut3 (.clock(clk), .reset_n(rst_n), .bus(b3));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_outputs(input string tag);
      check({tag, " m0_wr"}, b0.m0_waitrequest, 1);
      check({tag, " m1_wr"}, b0.m1_waitrequest, 1);
      check({tag, " m0_v"}, b0.m0_readdatavalid, 0);
      check({tag, " m1_v"}, b0.m1_readdatavalid, 0);
      check({tag, " s_addr"}, b0.s_address, 0);
   endtask
   task automatic reset_pulse;
      rst_n = 1'b0;
      #1;
      cyc;
      rst_n = 1'b1;
   endtask
   initial begin
      b0.m0_read = 0; b0.m0_address = 0; b0.m1_read = 0; b0.m1_address = 0;
      b3.m0_read = 0; b3.m0_address = 0; b3.m1_read = 0; b3.m1_address = 0;
      #2;
      idle_outputs("rst");
      check("rst m0_rd", b0.m0_readdata, 0);
      check("rst m1_rd", b0.m1_readdata, 0);
      cyc;
      rst_n = 1'b1;
      cyc;
      // single m0 read; address changes after grant must not matter
      b0.m0_read = 1; b0.m0_address = 1;
      check("r27 T m0_wr", b0.m0_waitrequest, 1);
      cyc;
      b0.m0_read = 0; b0.m0_address = 0;
      check("r27 T1 m0_wr", b0.m0_waitrequest, 0);
      check("r27 T1 m1_wr", b0.m1_waitrequest, 1);
      check("r27 T1 s_addr", b0.s_address, 1);
      cyc;
      check("r27 T2 m0_v", b0.m0_readdatavalid, 1);
      check("r27 T2 m0_rd", b0.m0_readdata, TS);
      check("r27 T2 m1_v", b0.m1_readdatavalid, 0);
      check("r27 T2 m1_wr", b0.m1_waitrequest, 1);
      cyc;
      idle_outputs("r27 T3");
      check("r27 T3 m0_rd hold", b0.m0_readdata, TS);
      // tie after reset: m0 first, then m1
      reset_pulse();
      b0.m0_read = 1; b0.m0_address = 1; b0.m1_read = 1; b0.m1_address = 0;
      cyc;
      b0.m0_read = 0;
      check("r28 T1 m0_wr", b0.m0_waitrequest, 0);
      check("r28 T1 m1_wr", b0.m1_waitrequest, 1);
      cyc;
      check("r28 T2 m0_v", b0.m0_readdatavalid, 1);
      check("r28 T2 m0_rd", b0.m0_readdata, TS);
      check("r28 T2 m1_v", b0.m1_readdatavalid, 0);
      cyc;
      check("r28 T3 m1_wr", b0.m1_waitrequest, 1);
      cyc;
      b0.m1_read = 0;
      check("r28 T4 m1_wr", b0.m1_waitrequest, 0);
      check("r28 T4 s_addr", b0.s_address, 0);
      cyc;
      check("r28 T5 m1_v", b0.m1_readdatavalid, 1);
      check("r28 T5 m1_rd", b0.m1_readdata, 0);
      check("r28 T5 m0_v", b0.m0_readdatavalid, 0);
      cyc;
      // continuous contention alternates starting with m0
      b0.m0_read = 1; b0.m0_address = 1; b0.m1_read = 1; b0.m1_address = 1;
      for (int k = 0; k < 6; k++) begin
         cyc;
         cyc;
         check($sformatf("r29 #%0d m0_v", k), b0.m0_readdatavalid, (k % 2 == 0) ? 1 : 0);
         check($sformatf("r29 #%0d m1_v", k), b0.m1_readdatavalid, (k % 2 == 1) ? 1 : 0);
         cyc;
         check($sformatf("r29 #%0d gap", k), {b0.m0_readdatavalid, b0.m1_readdatavalid}, 0);
      end
      b0.m0_read = 0;
      check("r29 m1_rd", b0.m1_readdata, TS);
      // m1 alone repeatedly, even though it was granted last
      for (int k = 0; k < 3; k++) begin
         cyc;
         check($sformatf("r31 #%0d m1_wr", k), b0.m1_waitrequest, 0);
         cyc;
         check($sformatf("r31 #%0d m1_v", k), b0.m1_readdatavalid, 1);
         cyc;
         check($sformatf("r31 #%0d idle", k), b0.m1_readdatavalid, 0);
      end
      b0.m1_read = 0;
      // WAIT_CYCLES=3 instance
      b3.m1_read = 1; b3.m1_address = 1;
      for (int i = 1; i <= 6; i++) begin
         cyc;
         b3.m1_read = 0;
         check($sformatf("r30 T%0d m1_wr", i), b3.m1_waitrequest, (i == 4) ? 1'b0 : 1'b1);
         check($sformatf("r30 T%0d m1_v", i), b3.m1_readdatavalid, (i == 5) ? 1'b1 : 1'b0);
         check($sformatf("r30 T%0d s_addr", i), b3.s_address, (i <= 5) ? 1'b1 : 1'b0);
      end
      check("r30 m1_rd", b3.m1_readdata, TS);
      check("r30 m0_v", b3.m0_readdatavalid, 0);
      // reset in ACCESS aborts the transaction
      b0.m0_read = 1; b0.m0_address = 1;
      cyc;
      b0.m0_read = 0;
      rst_n = 1'b0;
      #1;
      idle_outputs("r32 in rst");
      check("r32 in rst m0_rd", b0.m0_readdata, 0);
      cyc;
      idle_outputs("r32 rst hold");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc;
         idle_outputs($sformatf("r32 after %0d", i));
      end
      b0.m0_read = 1; b0.m0_address = 1;
      cyc;
      b0.m0_read = 0;
      check("r32 fresh m0_wr", b0.m0_waitrequest, 0);
      cyc;
      check("r32 fresh m0_v", b0.m0_readdatavalid, 1);
      check("r32 fresh m0_rd", b0.m0_readdata, TS);
      cyc;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/sysid_read_arbiter.md
SYSID_READ_ARBITER -- requirements
Module: sysid_read_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 0, meaning extra slave-access cycles before readdata is sampled (legal range 0-15).
REQ-002 SHALL have port clock, input, 1, meaning the sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port m0_read, input, 1, meaning requester 0 read request.
REQ-005 SHALL have port m0_address, input, 1, meaning requester 0 word address (0 = ID, 1 = timestamp).
REQ-006 SHALL have port m0_waitrequest, output, 1, meaning requester 0 stall; low marks acceptance.
REQ-007 SHALL have port m0_readdata, output, 32, meaning requester 0 read data.
REQ-008 SHALL have port m0_readdatavalid, output, 1, meaning m0_readdata valid this cycle.
REQ-009 SHALL have ports m1_read, m1_address, m1_waitrequest, m1_readdata, m1_readdatavalid, identical to REQ-004..008 for requester 1.
REQ-010 SHALL have port s_address, output, 1, meaning address driven to the shared system-ID slave.
REQ-011 SHALL have port s_readdata, input, 32, meaning combinational data returned by the system-ID slave.

Function
REQ-012 SHALL implement states IDLE, ACCESS, RESP.
REQ-013 IDLE: if any mN_read high, SHALL latch grant index and that requester's address, load wait counter with WAIT_CYCLES, and go to ACCESS next cycle; otherwise stay IDLE.
REQ-014 Arbitration SHALL be round-robin: only one requesting -> it wins; both requesting -> the one not granted last wins.
REQ-015 last_grant SHALL update on entry to RESP; after reset it SHALL equal 1, so m0 wins the first tie.
REQ-016 s_address SHALL equal the latched address in ACCESS and RESP, and 0 in IDLE.
REQ-017 ACCESS: counter nonzero -> decrement, stay; counter zero -> capture s_readdata into response register, go to RESP.
REQ-018 mN_waitrequest SHALL be low only in the ACCESS cycle with counter zero and grant = N; high in all other cycles, including when mN_read is low.
REQ-019 RESP: mN_readdatavalid of the granted requester SHALL be high for exactly one cycle with captured data on mN_readdata; then go to IDLE.
REQ-020 mN_readdata SHALL hold its last captured value when not valid; the non-granted requester's readdatavalid SHALL stay low.
REQ-021 Latency: read first sampled in IDLE at cycle T -> waitrequest low at T+1+WAIT_CYCLES, readdatavalid at T+2+WAIT_CYCLES.
REQ-022 Throughput: at most one read per 3+WAIT_CYCLES cycles; no new grant in ACCESS or RESP.
REQ-023 A requester dropping read or changing address after grant SHALL NOT abort the transaction; the latched address is used and readdatavalid is still issued.
REQ-024 A request arriving during ACCESS/RESP SHALL wait (waitrequest high) and be evaluated in the next IDLE.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, last_grant 1, counter 0, s_address 0, both readdata 0, both readdatavalid 0, both waitrequest 1.
REQ-026 Reset during ACCESS or RESP SHALL discard the transaction with no readdatavalid pulse; operation resumes from IDLE on the first clock after release.

Verification
REQ-027 Slave stub returns 0x00000000 (addr 0) and 0x51992A75 (addr 1), WAIT_CYCLES=0; m0 reads addr 1 at T -> m0_waitrequest low at T+1, m0_readdatavalid with 0x51992A75 at T+2, m1 outputs inactive.
REQ-028 m0 (addr 1) and m1 (addr 0) both assert read at T after reset -> m0 valid 0x51992A75 at T+2; m1 waitrequest low at T+4, valid 0x00000000 at T+5.
REQ-029 Both requesters hold read continuously for 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1, one valid every 3 cycles.
REQ-030 WAIT_CYCLES=3, m1 reads addr 1 at T -> m1_waitrequest low only at T+4, valid 0x51992A75 at T+5, s_address 1 from T+1 to T+5.
REQ-031 m1 alone issues 3 back-to-back reads -> each served (T+2, T+5, T+8) despite last_grant = 1.
REQ-032 reset_n pulsed low at T+1 of an m0 read -> no readdatavalid on either requester, both waitrequest high, s_address 0 during reset; a fresh read after release completes with normal latency.
